// File: rtl/regfile_write_arbiter_if.sv
// Write-side bus of the register-file arbiter: primary writeback, multdiv
// handshake, the register-file write port, and hazard status.
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          wb_valid;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_data;
  logic          wb_stall;

  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_reg;
  logic [31:0]   md_data;

  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;

  logic [31:0]   pending_mask;
  logic [CW-1:0] fifo_count;

  // The master side is the pipeline/multdiv/regfile environment.
  modport master (
    output wb_valid, wb_reg, wb_data,
    output md_valid, md_reg, md_data,
    input  wb_stall, md_ready,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  pending_mask, fifo_count
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  md_valid, md_reg, md_data,
    output wb_stall, md_ready,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output pending_mask, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Merges single-cycle writeback (priority) and buffered multdiv results onto
// the one register-file write port, with starvation relief for the FIFO.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           fifoMem [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic [PW-1:0]    headPtr;
  logic [PW-1:0]    tailPtr;
  logic [CW-1:0]    fifoCount;

  logic [SW-1:0]    starveCnt;
  logic [SW-1:0]    starveInc;
  logic             wbStall;

  logic             writeEnable;
  logic [4:0]       writeReg;
  logic [31:0]      writeData;
  logic [31:0]      pendMask;

  logic             fifoEmpty;
  logic             mdReady;
  logic             mdAccept;
  logic             fifoPush;
  logic             fifoPop;
  logic             wbGrant;

  // Readiness looks only at registered occupancy: no pass-through when full.
  assign fifoEmpty = (fifoCount == '0);
  assign mdReady   = !ctrl_reset && (fifoCount < FULL_COUNT);
  assign mdAccept  = bus.md_valid && mdReady;
  assign fifoPush  = mdAccept && (bus.md_reg != 5'd0);
  assign wbGrant   = bus.wb_valid && (bus.wb_reg != 5'd0) && !wbStall;
  assign fifoPop   = !wbGrant && !fifoEmpty;
  assign starveInc = starveCnt + SW'(1);

  // Pointer/occupancy bookkeeping; push and pop never hit the same slot
  // because pop needs a non-empty FIFO and push needs a non-full one.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      fifoCount  <= '0;
      entryValid <= '0;
    end else begin
      if (fifoPush) begin
        tailPtr             <= tailPtr + PW'(1);
        entryValid[tailPtr] <= 1'b1;
      end
      if (fifoPop) begin
        headPtr             <= headPtr + PW'(1);
        entryValid[headPtr] <= 1'b0;
      end
      case ({fifoPush, fifoPop})
        2'b10:   fifoCount <= fifoCount + CW'(1);
        2'b01:   fifoCount <= fifoCount - CW'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (fifoPush) fifoMem[tailPtr] <= '{rd: bus.md_reg, data: bus.md_data};
  end

  // Idle cycles keep the last address/data so the port only toggles enable.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
    end else if (wbGrant) begin
      writeEnable <= 1'b1;
      writeReg    <= bus.wb_reg;
      writeData   <= bus.wb_data;
    end else if (fifoPop) begin
      writeEnable <= 1'b1;
      writeReg    <= fifoMem[headPtr].rd;
      writeData   <= fifoMem[headPtr].data;
    end else begin
      writeEnable <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      starveCnt <= '0;
      wbStall   <= 1'b0;
    end else begin
      wbStall <= 1'b0;
      if (fifoPop || fifoEmpty) begin
        starveCnt <= '0;
      end else if (wbGrant) begin
        if (starveInc == STARVE_MAX) begin
          starveCnt <= '0;
          wbStall   <= 1'b1;
        end else begin
          starveCnt <= starveInc;
        end
      end
    end
  end

  always_comb begin
    pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) pendMask[fifoMem[i].rd] = 1'b1;
    end
  end

  assign bus.md_ready         = mdReady;
  assign bus.wb_stall         = wbStall;
  assign bus.ctrl_writeEnable = writeEnable;
  assign bus.ctrl_writeReg    = writeReg;
  assign bus.data_writeReg    = writeData;
  assign bus.pending_mask     = pendMask;
  assign bus.fifo_count       = fifoCount;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a queue-based model predicts each write; a negedge
// monitor compares whatever the register-file port emits.
module tb_regfile_write_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic clock = 1'b0;
  logic ctrl_reset;

  regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];    // model of queued multdiv results
  ent_t expQ[$];  // expected register-file writes, in order
  int   starve;
  bit   mStall;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] modelMask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  // Apply the arbitration rules to the inputs present at this edge.
  task automatic modelEdge();
    int   sz;
    bit   grant;
    bit   popped;
    ent_t e;
    sz = mq.size();
    if (ctrl_reset) begin
      mq.delete();
      starve = 0;
      mStall = 0;
      return;
    end
    grant  = bus.wb_valid && (bus.wb_reg != 5'd0) && !mStall;
    popped = 0;
    if (grant) begin
      e.rd = bus.wb_reg; e.data = bus.wb_data;
      expQ.push_back(e);
    end else if (sz > 0) begin
      expQ.push_back(mq.pop_front());
      popped = 1;
    end
    mStall = 0;
    if (popped || sz == 0) starve = 0;
    else if (grant) begin
      starve++;
      if (starve == STARVE_LIMIT) begin
        starve = 0;
        mStall = 1;
      end
    end
    if (bus.md_valid && sz < DEPTH && bus.md_reg != 5'd0) begin
      e.rd = bus.md_reg; e.data = bus.md_data;
      mq.push_back(e);
    end
  endtask

  task automatic checkStatus();
    chk("fifo_count",   32'(bus.fifo_count), 32'(mq.size()));
    chk("pending_mask", bus.pending_mask, modelMask());
    chk("md_ready",     32'(bus.md_ready), 32'(!ctrl_reset && mq.size() < DEPTH));
    chk("wb_stall",     32'(bus.wb_stall), 32'(mStall));
  endtask

  // One clock: drive at negedge, model the edge, then check status.
  task automatic cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic rst);
    bus.wb_valid = wv && !mStall;
    bus.wb_reg   = wr;
    bus.wb_data  = wd;
    bus.md_valid = mv;
    bus.md_reg   = mr;
    bus.md_data  = md;
    ctrl_reset   = rst;
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkStatus();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  // Monitor: every emitted write must be the next expected one.
  always @(negedge clock) begin
    ent_t e;
    if (bus.ctrl_writeEnable === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write reg=%0d data=%h @%0t",
                 bus.ctrl_writeReg, bus.data_writeReg, $time);
      end else begin
        e = expQ.pop_front();
        chk("write_reg",  32'(bus.ctrl_writeReg), 32'(e.rd));
        chk("write_data", bus.data_writeReg, e.data);
      end
    end
  end

  always @(posedge clock) begin
    if (ctrl_reset === 1'b0)
      assert (!(bus.wb_stall && bus.wb_valid)) else $error("wb_valid asserted during wb_stall");
  end

  initial begin
    bus.wb_valid = 0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.md_valid = 0; bus.md_reg = '0; bus.md_data = '0;
    ctrl_reset = 1;
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    chk("rst_we",    32'(bus.ctrl_writeEnable), 32'd0);
    chk("rst_reg",   32'(bus.ctrl_writeReg), 32'd0);
    chk("rst_data",  bus.data_writeReg, 32'd0);
    chk("rst_ready", 32'(bus.md_ready), 32'd0);
    idle(1);

    // primary-only write and wb_reg=0 suppression
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0);
    chk("t1_we",   32'(bus.ctrl_writeEnable), 32'd1);
    chk("t1_reg",  32'(bus.ctrl_writeReg), 32'd5);
    chk("t1_data", bus.data_writeReg, 32'hDEADBEEF);
    idle(1);
    chk("t1_we_off", 32'(bus.ctrl_writeEnable), 32'd0);
    cycle(1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0, 0);
    chk("t1_r0_we", 32'(bus.ctrl_writeEnable), 32'd0);

    // fill the FIFO behind a busy primary, then drain in order
    for (int i = 1; i <= 4; i++)
      cycle(1, 5'd20, 32'(100 + i), 1, 5'(i), 32'(32'hA000 + i), 0);
    chk("t2_count", 32'(bus.fifo_count), 32'd4);
    chk("t2_mask",  bus.pending_mask, 32'h1E);
    chk("t2_ready", 32'(bus.md_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      chk("t2_drain_reg", 32'(bus.ctrl_writeReg), 32'(i));
    end
    chk("t2_mask_clr", bus.pending_mask, 32'd0);
    idle(2);

    // push while popping keeps occupancy constant
    cycle(1, 5'd21, 32'h1, 1, 5'd10, 32'hB010, 0);
    cycle(1, 5'd21, 32'h2, 1, 5'd11, 32'hB011, 0);
    cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'hB007, 0);
    chk("t3_count", 32'(bus.fifo_count), 32'd2);
    chk("t3_reg0",  32'(bus.ctrl_writeReg), 32'd10);
    idle(1);
    chk("t3_reg1",  32'(bus.ctrl_writeReg), 32'd11);
    idle(1);
    chk("t3_reg7",  32'(bus.ctrl_writeReg), 32'd7);
    idle(2);

    // starvation relief
    cycle(1, 5'd3, 32'hC000, 1, 5'd9, 32'h9999, 0);
    for (int i = 0; i < STARVE_LIMIT - 1; i++) cycle(1, 5'd3, 32'(32'hC001 + i), 0, 5'd0, 32'd0, 0);
    chk("t4_no_stall_yet", 32'(bus.wb_stall), 32'd0);
    cycle(1, 5'd3, 32'hC0FF, 0, 5'd0, 32'd0, 0);
    chk("t4_stall", 32'(bus.wb_stall), 32'd1);
    cycle(1, 5'd3, 32'hC100, 0, 5'd0, 32'd0, 0);
    chk("t4_md_we",  32'(bus.ctrl_writeEnable), 32'd1);
    chk("t4_md_reg", 32'(bus.ctrl_writeReg), 32'd9);
    chk("t4_stall_off", 32'(bus.wb_stall), 32'd0);
    idle(2);

    // reset with queued results discards them
    for (int i = 1; i <= 3; i++)
      cycle(1, 5'd22, 32'(200 + i), 1, 5'(i + 12), 32'(32'hD000 + i), 0);
    chk("t5_count", 32'(bus.fifo_count), 32'd3);
    chk("t5_we",    32'(bus.ctrl_writeEnable), 32'd1);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    chk("t5_we0",    32'(bus.ctrl_writeEnable), 32'd0);
    chk("t5_reg0",   32'(bus.ctrl_writeReg), 32'd0);
    chk("t5_data0",  bus.data_writeReg, 32'd0);
    chk("t5_mask0",  bus.pending_mask, 32'd0);
    chk("t5_ready0", 32'(bus.md_ready), 32'd0);
    idle(1);
    chk("t5_ready1", 32'(bus.md_ready), 32'd1);
    idle(4);

    // md_reg=0 is accepted and dropped
    cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'hEEEE, 0);
    chk("t6_count", 32'(bus.fifo_count), 32'd0);
    idle(1);
    chk("t6_we", 32'(bus.ctrl_writeEnable), 32'd0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 99) == 0));
    end
    idle(DEPTH + 2);
    chk("exp_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
